// File: rtl/decode_pkg.sv
// Shared opcode map, FSM encoding and decode helpers for the decode stage.
package decode_pkg;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_HLT  = 5'b00001;
  localparam logic [4:0] OP_LDM  = 5'b10100;
  localparam logic [4:0] OP_LDD  = 5'b10101;
  localparam logic [4:0] OP_STD  = 5'b10110;
  localparam logic [4:0] OP_JZ   = 5'b11000;
  localparam logic [4:0] OP_JMP  = 5'b11001;
  localparam logic [4:0] OP_CALL = 5'b11010;
  localparam logic [4:0] OP_RET  = 5'b11011;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic use_imm;
    logic branch;
    logic jump;
  } ctrl_t;

  function automatic logic is_alu(input logic [4:0] op);
    return op[4:3] == 2'b01;
  endfunction

  function automatic logic is_imm(input logic [4:0] op);
    return (op == OP_LDM) || (op == OP_LDD) || (op == OP_STD);
  endfunction

  function automatic logic is_jump(input logic [4:0] op);
    return (op == OP_JMP) || (op == OP_CALL) || (op == OP_RET);
  endfunction

  function automatic logic reads_rd(input logic [4:0] op);
    return is_alu(op) || (op == OP_STD) || (op == OP_JZ) || (op == OP_JMP) || (op == OP_CALL);
  endfunction

  function automatic logic is_known(input logic [4:0] op);
    return (op == OP_HLT) || is_alu(op) || is_imm(op) || (op == OP_JZ) || is_jump(op);
  endfunction

  function automatic ctrl_t decode_ctrl(input logic [4:0] op);
    ctrl_t c;
    c           = '0;
    c.reg_write = is_alu(op) || (op == OP_LDM) || (op == OP_LDD);
    c.mem_read  = (op == OP_LDD);
    c.mem_write = (op == OP_STD);
    c.use_imm   = is_imm(op);
    c.branch    = (op == OP_JZ);
    c.jump      = is_jump(op);
    return c;
  endfunction

endpackage

// File: rtl/register_file.sv
// 8-entry register file: one write port, two combinational read ports with write-through.
module register_file #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Bypass so a reader in the write cycle sees the value being written.
  assign rdata_a = (we && waddr == raddr_a) ? wdata : regs[raddr_a];
  assign rdata_b = (we && waddr == raddr_b) ? wdata : regs[raddr_b];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: IF/ID register, register file, control decode, load-use stall and HLT freeze.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 32,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [4:0]        if_opcode,
  input  logic [2:0]        if_rs,
  input  logic [2:0]        if_rd,
  input  logic [4:0]        if_shmnt,
  input  logic [15:0]       if_word,
  input  logic [PC_W-1:0]   if_next_pc,
  input  logic              flush,
  input  logic              ex_mem_read,
  input  logic [2:0]        ex_rd,
  input  logic              wb_en,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ldm_signal,
  output logic              stall,
  output logic              halted,
  output logic              id_valid,
  output logic [4:0]        id_opcode,
  output logic [2:0]        id_rs,
  output logic [2:0]        id_rd,
  output logic [4:0]        id_shmnt,
  output logic [DATA_W-1:0] id_rs_data,
  output logic [DATA_W-1:0] id_rd_data,
  output logic [DATA_W-1:0] id_imm,
  output logic [PC_W-1:0]   id_next_pc,
  output logic              id_reg_write,
  output logic              id_mem_read,
  output logic              id_mem_write,
  output logic              id_use_imm,
  output logic              id_branch,
  output logic              id_jump
);

  typedef struct packed {
    logic [4:0]      opcode;
    logic [2:0]      rs;
    logic [2:0]      rd;
    logic [4:0]      shmnt;
    logic [PC_W-1:0] next_pc;
  } ifid_t;

  typedef struct packed {
    logic              valid;
    logic [4:0]        opcode;
    logic [2:0]        rs;
    logic [2:0]        rd;
    logic [4:0]        shmnt;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] imm;
    logic [PC_W-1:0]   next_pc;
    ctrl_t             ctrl;
  } idex_t;

  ifid_t             ifid, ifid_next, fetch;
  idex_t             idex, idex_next;
  logic [0:0]        state, state_next;
  logic              ifid_valid, hazard, issue;
  logic [DATA_W-1:0] rs_data, rd_data;

  register_file #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_en & enable),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (ifid.rs),
    .rdata_a (rs_data),
    .raddr_b (ifid.rd),
    .rdata_b (rd_data)
  );

  assign fetch      = '{opcode: if_opcode, rs: if_rs, rd: if_rd, shmnt: if_shmnt, next_pc: if_next_pc};
  assign ifid_valid = (ifid.opcode != OP_NOP);
  assign hazard     = ex_mem_read & ifid_valid &
                      ((ex_rd == ifid.rs) | ((ex_rd == ifid.rd) & reads_rd(ifid.opcode)));
  assign ldm_signal = ifid_valid & is_imm(ifid.opcode) & ~flush & (state == ST_RUN);
  assign stall      = ~flush & ((state == ST_HALT) | hazard);
  assign issue      = ~flush & (state == ST_RUN) & ~hazard;
  assign halted     = (state == ST_HALT);

  // Next IF/ID, ID/EX and FSM state in priority order: flush, HALT/hazard hold, normal advance.
  always_comb begin
    ifid_next  = ifid;
    idex_next  = '0;
    state_next = state;
    if (flush) begin
      ifid_next = '0;
    end else if (issue) begin
      ifid_next = ldm_signal ? '0 : fetch;
      if (is_known(ifid.opcode)) begin
        idex_next.valid   = 1'b1;
        idex_next.opcode  = ifid.opcode;
        idex_next.rs      = ifid.rs;
        idex_next.rd      = ifid.rd;
        idex_next.shmnt   = ifid.shmnt;
        idex_next.rs_data = rs_data;
        idex_next.rd_data = rd_data;
        idex_next.imm     = is_imm(ifid.opcode) ? if_word : '0;
        idex_next.next_pc = ifid.next_pc;
        idex_next.ctrl    = decode_ctrl(ifid.opcode);
        if (ifid.opcode == OP_HLT) state_next = ST_HALT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid  <= '0;
      idex  <= '0;
      state <= ST_RUN;
    end else if (enable) begin
      ifid  <= ifid_next;
      idex  <= idex_next;
      state <= state_next;
    end
  end

  assign id_valid     = idex.valid;
  assign id_opcode    = idex.opcode;
  assign id_rs        = idex.rs;
  assign id_rd        = idex.rd;
  assign id_shmnt     = idex.shmnt;
  assign id_rs_data   = idex.rs_data;
  assign id_rd_data   = idex.rd_data;
  assign id_imm       = idex.imm;
  assign id_next_pc   = idex.next_pc;
  assign id_reg_write = idex.ctrl.reg_write;
  assign id_mem_read  = idex.ctrl.mem_read;
  assign id_mem_write = idex.ctrl.mem_write;
  assign id_use_imm   = idex.ctrl.use_imm;
  assign id_branch    = idex.ctrl.branch;
  assign id_jump      = idex.ctrl.jump;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, enable, flush, ex_mem_read, wb_en;
  logic [4:0]  if_opcode, if_shmnt;
  logic [2:0]  if_rs, if_rd, ex_rd, wb_addr;
  logic [15:0] if_word, wb_data;
  logic [31:0] if_next_pc;
  logic        ldm_signal, stall, halted, id_valid;
  logic [4:0]  id_opcode, id_shmnt;
  logic [2:0]  id_rs, id_rd;
  logic [15:0] id_rs_data, id_rd_data, id_imm;
  logic [31:0] id_next_pc;
  logic        id_reg_write, id_mem_read, id_mem_write, id_use_imm, id_branch, id_jump;

  decode_stage dut (
    .clk(clk), .reset(reset), .enable(enable),
    .if_opcode(if_opcode), .if_rs(if_rs), .if_rd(if_rd), .if_shmnt(if_shmnt),
    .if_word(if_word), .if_next_pc(if_next_pc), .flush(flush),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ldm_signal(ldm_signal), .stall(stall), .halted(halted),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs), .id_rd(id_rd),
    .id_shmnt(id_shmnt), .id_rs_data(id_rs_data), .id_rd_data(id_rd_data),
    .id_imm(id_imm), .id_next_pc(id_next_pc),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_use_imm(id_use_imm), .id_branch(id_branch), .id_jump(id_jump)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [4:0]  op;
    logic [2:0]  rs, rd;
    logic [4:0]  sh;
    logic [15:0] rsd, rdd, imm;
    logic [31:0] pc;
    logic [5:0]  ctrl;
  } exp_t;

  int checks = 0;
  int errors = 0;

  // Model state: IF/ID contents, halt flag, architectural registers, expected ID/EX.
  logic [4:0]  m_op, m_sh;
  logic [2:0]  m_rs, m_rd;
  logic [31:0] m_pc;
  logic        m_halt;
  logic [15:0] m_regs [8];
  exp_t        e;
  logic        obs_ldm, obs_stall;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit known(input logic [4:0] op);
    return op inside {5'd1, [5'd8:5'd15], [5'd20:5'd22], [5'd24:5'd27]};
  endfunction

  function automatic logic [15:0] rd_reg(input logic [2:0] idx);
    return (wb_en && wb_addr == idx) ? wb_data : m_regs[idx];
  endfunction

  task automatic model_clear();
    m_op = 0; m_rs = 0; m_rd = 0; m_sh = 0; m_pc = 0; m_halt = 0; e = '0;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
  endtask

  task automatic cycle();
    bit   rdr, hz, imm, ldm_e, stall_e, adv;
    exp_t n;
    #1;
    imm     = m_op inside {[5'd20:5'd22]};
    rdr     = m_op inside {[5'd8:5'd15], 5'd22, 5'd24, 5'd25, 5'd26};
    hz      = ex_mem_read && (m_op != 0) && (ex_rd == m_rs || (ex_rd == m_rd && rdr));
    ldm_e   = imm && !flush && !m_halt;
    stall_e = !flush && (m_halt || hz);
    obs_ldm = ldm_signal;
    obs_stall = stall;
    chk("ldm_signal", {63'd0, ldm_signal}, {63'd0, ldm_e});
    chk("stall", {63'd0, stall}, {63'd0, stall_e});
    if (enable) begin
      adv = !flush && !m_halt && !hz;
      n = '0;
      if (adv && known(m_op)) begin
        n.valid = 1; n.op = m_op; n.rs = m_rs; n.rd = m_rd; n.sh = m_sh; n.pc = m_pc;
        n.rsd = rd_reg(m_rs); n.rdd = rd_reg(m_rd);
        n.imm = imm ? if_word : 16'h0;
        n.ctrl = {m_op inside {[5'd8:5'd15], 5'd20, 5'd21}, m_op == 5'd21, m_op == 5'd22,
                  imm, m_op == 5'd24, m_op inside {[5'd25:5'd27]}};
        if (m_op == 5'd1) m_halt = 1;
      end
      e = n;
      if (flush || (adv && ldm_e)) begin
        m_op = 0; m_rs = 0; m_rd = 0; m_sh = 0; m_pc = 0;
      end else if (adv) begin
        m_op = if_opcode; m_rs = if_rs; m_rd = if_rd; m_sh = if_shmnt; m_pc = if_next_pc;
      end
      if (wb_en) m_regs[wb_addr] = wb_data;
    end
    @(posedge clk);
    #1;
    chk("id_valid", {63'd0, id_valid}, {63'd0, e.valid});
    chk("id_fields", {48'd0, id_opcode, id_rs, id_rd, id_shmnt}, {48'd0, e.op, e.rs, e.rd, e.sh});
    chk("id_rs_data", {48'd0, id_rs_data}, {48'd0, e.rsd});
    chk("id_rd_data", {48'd0, id_rd_data}, {48'd0, e.rdd});
    chk("id_imm", {48'd0, id_imm}, {48'd0, e.imm});
    chk("id_next_pc", {32'd0, id_next_pc}, {32'd0, e.pc});
    chk("id_ctrl", {58'd0, id_reg_write, id_mem_read, id_mem_write, id_use_imm, id_branch, id_jump},
        {58'd0, e.ctrl});
    chk("halted", {63'd0, halted}, {63'd0, m_halt});
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_halted", {63'd0, halted}, 64'd0);
    chk("rst_id_valid", {63'd0, id_valid}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic fetch(input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rd);
    if_opcode = op; if_rs = rs; if_rd = rd; if_shmnt = 5'd3;
    if_next_pc = if_next_pc + 32'd1; if_word = 16'h0;
  endtask

  task automatic wb(input logic en, input logic [2:0] a, input logic [15:0] d);
    wb_en = en; wb_addr = a; wb_data = d;
  endtask

  logic [4:0] optab [11] = '{5'd0, 5'd8, 5'd11, 5'd15, 5'd20, 5'd21, 5'd22, 5'd24, 5'd25, 5'd26, 5'd27};

  initial begin
    reset = 1'b1; enable = 1'b1; flush = 0; ex_mem_read = 0; ex_rd = 0;
    if_next_pc = 32'h100; fetch(5'd0, 3'd0, 3'd0); wb(0, 3'd0, 16'h0);
    model_clear();
    @(posedge clk); #1;
    chk("reset_valid", {63'd0, id_valid}, 64'd0);
    chk("reset_halted", {63'd0, halted}, 64'd0);
    chk("reset_ldm", {63'd0, ldm_signal}, 64'd0);
    reset = 1'b0;

    // ALU op reading r1 and r2
    wb(1, 3'd1, 16'h0005); cycle();
    wb(1, 3'd2, 16'h0003); cycle();
    wb(0, 3'd0, 16'h0); fetch(5'b01000, 3'd1, 3'd2); cycle();
    fetch(5'd0, 3'd0, 3'd0); cycle();
    chk("alu_valid", {63'd0, id_valid}, 64'd1);
    chk("alu_rs_data", {48'd0, id_rs_data}, 64'h5);
    chk("alu_rd_data", {48'd0, id_rd_data}, 64'h3);
    chk("alu_reg_write", {63'd0, id_reg_write}, 64'd1);
    chk("alu_imm", {48'd0, id_imm}, 64'd0);

    // LDM with immediate word
    fetch(5'b10100, 3'd0, 3'd4); cycle();
    fetch(5'd0, 3'd0, 3'd0); if_word = 16'hBEEF; cycle();
    chk("ldm_sig", {63'd0, obs_ldm}, 64'd1);
    chk("ldm_imm", {48'd0, id_imm}, 64'hBEEF);
    chk("ldm_use_imm", {63'd0, id_use_imm}, 64'd1);
    fetch(5'd0, 3'd0, 3'd0); cycle();
    chk("ldm_bubble", {63'd0, id_valid}, 64'd0);

    // Load-use hazard with write-back during the stall
    fetch(5'b01000, 3'd1, 3'd3); cycle();
    ex_mem_read = 1; ex_rd = 3'd1; wb(1, 3'd1, 16'h7777); fetch(5'd0, 3'd0, 3'd0); cycle();
    chk("hz_stall", {63'd0, obs_stall}, 64'd1);
    chk("hz_bubble", {63'd0, id_valid}, 64'd0);
    ex_mem_read = 0; wb(0, 3'd0, 16'h0); cycle();
    chk("hz_release", {63'd0, obs_stall}, 64'd0);
    chk("hz_issue", {63'd0, id_valid}, 64'd1);
    chk("hz_fwd_data", {48'd0, id_rs_data}, 64'h7777);

    // Write-through on simultaneous write and read
    fetch(5'b01001, 3'd1, 3'd1); cycle();
    wb(1, 3'd1, 16'h1234); fetch(5'd0, 3'd0, 3'd0); cycle();
    chk("wt_rs_data", {48'd0, id_rs_data}, 64'h1234);
    wb(0, 3'd0, 16'h0);

    // Flush while LDM sits in IF/ID
    fetch(5'b10100, 3'd2, 3'd4); cycle();
    flush = 1; fetch(5'b01010, 3'd2, 3'd2); cycle();
    chk("fl_ldm", {63'd0, obs_ldm}, 64'd0);
    chk("fl_idex", {63'd0, id_valid}, 64'd0);
    flush = 0; fetch(5'd0, 3'd0, 3'd0); cycle();
    chk("fl_ifid", {63'd0, id_valid}, 64'd0);

    // HLT freezes until reset
    fetch(5'd1, 3'd0, 3'd0); cycle();
    fetch(5'b01000, 3'd0, 3'd0); cycle();
    chk("hlt_issue", {63'd0, id_valid}, 64'd1);
    chk("hlt_halted", {63'd0, halted}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      fetch(5'($urandom_range(8, 15)), 3'($urandom), 3'($urandom));
      cycle();
      chk("hlt_stall", {63'd0, obs_stall}, 64'd1);
      chk("hlt_bubble", {63'd0, id_valid}, 64'd0);
    end
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) fetch(5'd1, 3'($urandom), 3'($urandom));
      else if (r < 8) fetch(5'($urandom), 3'($urandom), 3'($urandom));
      else fetch(optab[$urandom_range(0, 10)], 3'($urandom), 3'($urandom));
      if_shmnt = 5'($urandom);
      if_word = 16'($urandom);
      if_next_pc = $urandom;
      enable = ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 7) == 0);
      ex_mem_read = ($urandom_range(0, 2) == 0);
      ex_rd = 3'($urandom_range(0, 3));
      wb($urandom_range(0, 1) == 1, 3'($urandom), 16'($urandom));
      if (m_halt && $urandom_range(0, 3) == 0) do_reset();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
